// File: rtl/mult_arb_pkg.sv
// Shared widths and FSM state type for the shared-multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OPW  = 4;   // operand width
    localparam int unsigned PW   = 8;   // product width
    localparam int unsigned CNTW = 16;  // completed-response counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mult_share_arbiter_mul.sv
// 4x4 unsigned array multiplier: sums the shifted partial-product rows.
module mult_share_arbiter_mul
    import mult_arb_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    // Accumulate one partial-product row per bit of b.
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < OPW; i++) begin
            if (b[i]) begin
                p = p + (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x4 multiplier among NREQ requesters.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [OPW*NREQ-1:0]  req_a,
    input  logic [OPW*NREQ-1:0]  req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PW-1:0]        rsp_p,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [OPW-1:0]  op_a_q, op_a_d;
    logic [OPW-1:0]  op_b_q, op_b_d;
    logic [PW-1:0]   rsp_p_q, rsp_p_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic [IDW:0]    pick;
    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    logic [OPW-1:0]  sel_a, sel_b;
    logic [PW-1:0]   mul_p;

    // First set valid bit at or after p+1, wrapping modulo NREQ.
    // Scanning from the far end lets the nearest candidate win last.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0] r;
        int unsigned  j;
        r = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            j = (32'(p) + k) % NREQ;
            if (v[j]) begin
                r = {1'b1, IDW'(j)};
            end
        end
        return r;
    endfunction

    // Round-robin choice and operand slice of the chosen requester.
    always_comb begin
        pick     = rr_pick(req_valid, ptr_q);
        pick_vld = pick[IDW];
        pick_idx = pick[IDW-1:0];
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    mult_share_arbiter_mul u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // Sequencer: accept in IDLE, capture product in MUL, hold response in RESP.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rsp_p_d    = rsp_p_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    id_d    = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = MUL;
                end
            end
            MUL: begin
                rsp_p_d  = mul_p;
                rsp_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NREQ - 1);
            id_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rsp_p_q    <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rsp_p_q    <= rsp_p_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = (state_q == IDLE && pick_vld) ? (NREQ'(1) << pick_idx) : '0;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a transaction-level reference model.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [15:0]       op_count;

    int n_vec = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one transaction in flight at a time; the winner is the first
    // valid requester after the last one served, wrapping around.
    function automatic int rr(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    bit m_busy;
    int m_age, m_ptr, m_id, m_prod, m_rsp_p, m_rsp_id, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_age    <= 0;
            m_ptr    <= NREQ - 1;
            m_rsp_p  <= 0;
            m_rsp_id <= 0;
            m_cnt    <= 0;
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_age    <= 2;
                m_rsp_p  <= m_prod;
                m_rsp_id <= m_id;
            end else if (rsp_ready) begin
                m_busy <= 1'b0;
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            end
        end else begin
            g = rr(req_valid, m_ptr);
            if (g >= 0) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_id   <= g;
                m_ptr  <= g;
                m_prod <= int'(req_a[4*g +: 4]) * int'(req_b[4*g +: 4]);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        if (cmp_en && rst_n) begin
            exp_rdy = '0;
            if (!m_busy) begin
                g = rr(req_valid, m_ptr);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), (m_busy && m_age == 2) ? 1 : 0);
            chk("busy",      32'(busy),      32'(m_busy));
            chk("rsp_p",     32'(rsp_p),     m_rsp_p);
            chk("rsp_id",    32'(rsp_id),    m_rsp_id);
            chk("op_count",  32'(op_count),  m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
    endtask

    initial begin
        int gl[$];
        int gc[$];
        int pl[$];
        int eg[5] = '{0, 1, 2, 3, 0};
        int ep[5] = '{3, 6, 9, 12, 3};
        int ec[5] = '{0, 3, 6, 9, 12};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_rsp_p",    32'(rsp_p), 0);
        chk("rst_rsp_id",   32'(rsp_id), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);

        // Single request 15*15 on requester 2
        req_a[11:8] = 4'd15;
        req_b[11:8] = 4'd15;
        req_valid   = 4'b0100;
        #1;
        chk("t1_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("t1_mul_valid", 32'(rsp_valid), 0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_p",     32'(rsp_p), 225);
        chk("t1_rsp_id",    32'(rsp_id), 2);
        tick();
        chk("t1_op_count",  32'(op_count), 1);
        chk("t1_idle",      32'(busy), 0);

        // All requesters valid: round-robin order and 3-cycle issue interval
        do_reset();
        req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_b     = 16'h3333;
        req_valid = 4'hF;
        #1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gl.push_back(i);
                gc.push_back(cyc);
            end
            if (rsp_valid) pl.push_back(int'(rsp_p));
            tick();
        end
        req_valid = '0;
        chk("t2_ngrants", gl.size(), 5);
        chk("t2_nprods",  pl.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gl.size()) chk("t2_grant_id",    gl[i], eg[i]);
            if (i < gc.size()) chk("t2_grant_cycle", gc[i], ec[i]);
            if (i < pl.size()) chk("t2_product",     pl[i], ep[i]);
        end

        // Backpressure: 7*9 held under rsp_ready low, other requests ignored
        rsp_ready  = 1'b0;
        req_a[7:4] = 4'd7;
        req_b[7:4] = 4'd9;
        req_valid  = 4'b0010;
        #1;
        chk("t3_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'hF;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_rsp_valid", 32'(rsp_valid), 1);
            chk("t3_rsp_p",     32'(rsp_p), 63);
            chk("t3_rsp_id",    32'(rsp_id), 1);
            chk("t3_req_ready", 32'(req_ready), 0);
            chk("t3_busy",      32'(busy), 1);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("t3_idle_busy",  32'(busy), 0);
        chk("t3_idle_valid", 32'(rsp_valid), 0);

        // Operand change after acceptance must not disturb the product
        req_a[15:12] = 4'd5;
        req_b[15:12] = 4'd6;
        req_valid    = 4'b1000;
        #1;
        tick();
        req_valid = '0;
        req_a     = '0;
        tick();
        chk("t4_rsp_p",  32'(rsp_p), 30);
        chk("t4_rsp_id", 32'(rsp_id), 3);
        tick();

        // Reset during MUL discards the operation and restores priority
        do_reset();
        req_a       = {4'd4, 4'd3, 4'd2, 4'd1};
        req_a[11:8] = 4'd3;
        req_b[11:8] = 4'd3;
        req_valid   = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        chk("t5_busy_mul", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        chk("t5_rst_busy",  32'(busy), 0);
        chk("t5_rst_cnt",   32'(op_count), 0);
        tick();
        tick();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("t5_rsp_valid", 32'(rsp_valid), 1);
        chk("t5_rsp_p",     32'(rsp_p), 3);
        chk("t5_rsp_id",    32'(rsp_id), 0);
        chk("t5_cnt_before", 32'(op_count), 0);
        tick();
        chk("t5_cnt_after", 32'(op_count), 1);

        // Exhaustive operands through requester 1
        do_reset();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req_a[7:4] = 4'(a);
                req_b[7:4] = 4'(b);
                req_valid  = 4'b0010;
                #1;
                tick();
                req_valid = '0;
                tick();
                chk("t6_rsp_p", 32'(rsp_p), a * b);
                tick();
            end
        end
        chk("t6_op_count", 32'(op_count), 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
